// File: rtl/cordic_pkg.sv
// Shared constants and types for the rotation and vectoring CORDIC pair.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cordic_pkg;

    // Fixed-point formats at the block boundaries.
    localparam int MAG_W     = 12;  // unsigned 4.8 magnitude
    localparam int MAG_FRAC  = 8;
    localparam int PHASE_W   = 21;  // unsigned, full scale 2^21 = one turn
    localparam int CART_W    = 12;  // signed s3.8 cartesian
    localparam int CART_FRAC = 8;

    // Internal datapath formats.
    localparam int XY_FRAC     = 14;  // x/y carry 14 fractional bits
    localparam int IW_DEFAULT  = 20;  // sign + 5 int + 14 frac
    localparam int ZW_DEFAULT  = 22;  // residual angle, same LSB as phase

    // Inverse CORDIC gain, 1.14 unsigned (0.607239).
    localparam int              KINV_W = 14;
    localparam logic [KINV_W-1:0] KINV = 14'h26DD;

    // Arctangent table: 18 entries, so iteration count is legal in 12..18.
    localparam int ATAN_N       = 18;
    localparam int ATAN_W       = 19;
    localparam int ATAN_IDX_W   = 5;
    localparam int ITER_DEFAULT = 18;
    localparam int ITER_MIN     = 12;

    // Quadrant taken from the top two phase bits.
    typedef enum logic [1:0] {
        QUAD_0   = 2'd0,
        QUAD_90  = 2'd1,
        QUAD_180 = 2'd2,
        QUAD_270 = 2'd3
    } quad_t;

    // Rotator control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_POST = 2'd2
    } rot_state_t;

    // atan(2^-i) expressed in phase LSBs (360/2^21 deg).
    function automatic logic [ATAN_W-1:0] atan_lut(input logic [ATAN_IDX_W-1:0] idx);
        logic [ATAN_W-1:0] v;
        case (idx)
            5'd0:    v = 19'h40000;
            5'd1:    v = 19'h25C81;
            5'd2:    v = 19'h13F67;
            5'd3:    v = 19'h0A222;
            5'd4:    v = 19'h05162;
            5'd5:    v = 19'h028BB;
            5'd6:    v = 19'h0145F;
            5'd7:    v = 19'h00A30;
            5'd8:    v = 19'h00518;
            5'd9:    v = 19'h0028B;
            5'd10:   v = 19'h00146;
            5'd11:   v = 19'h000A3;
            5'd12:   v = 19'h00051;
            5'd13:   v = 19'h00029;
            5'd14:   v = 19'h00014;
            5'd15:   v = 19'h0000A;
            5'd16:   v = 19'h00005;
            5'd17:   v = 19'h00003;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_rotator_if.sv
// Polar-in / rectangular-out bus for the rotation CORDIC.
// Latency: none (wires only).
// Backpressure: in_ready gates the input side; the result side cannot stall.
interface cordic_rotator_if;
    import cordic_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [MAG_W-1:0]         in_mag;
    logic [PHASE_W-1:0]       in_phase;
    logic                     out_valid;
    logic signed [CART_W-1:0] out_x;
    logic signed [CART_W-1:0] out_y;

    // Producer of samples / consumer of results.
    modport master (
        output in_valid, in_mag, in_phase,
        input  in_ready, out_valid, out_x, out_y
    );

    // The rotator itself.
    modport slave (
        input  in_valid, in_mag, in_phase,
        output in_ready, out_valid, out_x, out_y
    );
endinterface

// File: rtl/cordic_rot_post.sv
// Quadrant restore, round half-up to s3.8 and saturate the converged x/y.
// Latency: combinational; the parent registers the result.
// Backpressure: none.
module cordic_rot_post
    import cordic_pkg::*;
#(
    parameter int IW = IW_DEFAULT
) (
    input  quad_t                    quad,
    input  logic signed [IW-1:0]     x,
    input  logic signed [IW-1:0]     y,
    output logic signed [CART_W-1:0] res_x,
    output logic signed [CART_W-1:0] res_y
);
    // One guard bit so negating the most negative x/y cannot wrap.
    localparam int EW = IW + 1;
    localparam int SH = XY_FRAC - CART_FRAC;
    localparam logic signed [EW-1:0] HALF   = EW'(1 << (SH - 1));
    localparam logic signed [EW-1:0] SAT_HI = EW'((1 << (CART_W - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_LO = EW'(-(1 << (CART_W - 1)));

    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] ye;
    logic signed [EW-1:0] sel_x;
    logic signed [EW-1:0] sel_y;

    assign xe = {x[IW-1], x};
    assign ye = {y[IW-1], y};

    // Add half an output LSB, drop the extra fraction bits, clamp to s3.8.
    function automatic logic signed [CART_W-1:0] round_sat(input logic signed [EW-1:0] v);
        logic signed [EW-1:0] r;
        r = (v + HALF) >>> SH;
        if (r > SAT_HI) begin
            return SAT_HI[CART_W-1:0];
        end else if (r < SAT_LO) begin
            return SAT_LO[CART_W-1:0];
        end else begin
            return r[CART_W-1:0];
        end
    endfunction

    // Rotate the first-quadrant result back by a multiple of 90 degrees.
    always_comb begin
        sel_x = xe;
        sel_y = ye;
        case (quad)
            QUAD_0: begin
                sel_x = xe;
                sel_y = ye;
            end
            QUAD_90: begin
                sel_x = -ye;
                sel_y = xe;
            end
            QUAD_180: begin
                sel_x = -xe;
                sel_y = -ye;
            end
            QUAD_270: begin
                sel_x = ye;
                sel_y = -xe;
            end
            default: begin
                sel_x = xe;
                sel_y = ye;
            end
        endcase
    end

    assign res_x = round_sat(sel_x);
    assign res_y = round_sat(sel_y);

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: polar (4.8 magnitude, 21-bit phase) to s3.8 x/y.
// Latency: ITER+1 cycles from accept to the one-cycle out_valid; one sample every ITER+2 cycles.
// Backpressure: in_ready high only when idle; results are not stallable.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT,  // legal range ITER_MIN..ATAN_N
    parameter int IW   = IW_DEFAULT,
    parameter int ZW   = ZW_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    cordic_rotator_if.slave bus
);
    localparam int CW       = $clog2(ITER);
    localparam int PROD_W   = MAG_W + KINV_W + 1;
    localparam int QUAD_LSB = PHASE_W - 2;

    rot_state_t               state;
    rot_state_t               state_nxt;
    logic [CW-1:0]            cnt;
    quad_t                    quad;
    logic signed [IW-1:0]     x;
    logic signed [IW-1:0]     y;
    logic signed [ZW-1:0]     z;
    logic signed [IW-1:0]     x_shr;
    logic signed [IW-1:0]     y_shr;
    logic signed [IW-1:0]     x_load;
    logic signed [ZW-1:0]     atan_z;
    logic [PROD_W-1:0]        prod;
    logic                     accept;
    logic                     last_iter;
    logic signed [CART_W-1:0] post_x;
    logic signed [CART_W-1:0] post_y;
    logic signed [CART_W-1:0] out_x_r;
    logic signed [CART_W-1:0] out_y_r;
    logic                     out_valid_r;

    assign accept    = bus.in_valid && (state == ST_IDLE);
    assign last_iter = (cnt == CW'(ITER - 1));

    // Pre-scale by 1/K so the CORDIC gain lands the result at unit scale.
    // 4.8 * 1.14 gives 22 fraction bits; truncating 8 leaves the 14 used inside.
    assign prod   = PROD_W'(bus.in_mag) * PROD_W'(KINV);
    assign x_load = IW'(prod >> MAG_FRAC);

    assign x_shr  = x >>> cnt;
    assign y_shr  = y >>> cnt;
    assign atan_z = ZW'(atan_lut(ATAN_IDX_W'(cnt)));

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: idle until accept, ITER micro-rotations, one output cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_ITER;
            ST_ITER: if (last_iter) state_nxt = ST_POST;
            ST_POST: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, rotate toward z=0, capture result in POST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            quad        <= QUAD_0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            out_x_r     <= '0;
            out_y_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state == ST_POST);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // Top two phase bits pick the quadrant; the rest is
                        // 0..<90 deg, inside the CORDIC convergence range.
                        quad <= quad_t'(bus.in_phase[PHASE_W-1 -: 2]);
                        z    <= ZW'(bus.in_phase[QUAD_LSB-1:0]);
                        x    <= x_load;
                        y    <= '0;
                        cnt  <= '0;
                    end
                end
                ST_ITER: begin
                    if (!z[ZW-1]) begin
                        x <= x - y_shr;
                        y <= y + x_shr;
                        z <= z - atan_z;
                    end else begin
                        x <= x + y_shr;
                        y <= y - x_shr;
                        z <= z + atan_z;
                    end
                    cnt <= last_iter ? '0 : cnt + 1'b1;
                end
                ST_POST: begin
                    out_x_r <= post_x;
                    out_y_r <= post_y;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    cordic_rot_post #(
        .IW (IW)
    ) u_post (
        .quad  (quad),
        .x     (x),
        .y     (y),
        .res_x (post_x),
        .res_y (post_y)
    );

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_x     = out_x_r;
    assign bus.out_y     = out_y_r;

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator against a floating-point polar-to-rect model.
// Latency: checks accept-to-out_valid distance and the per-sample issue interval.
// Backpressure: holds in_valid high through busy periods with junk data.
module tb_cordic_rotator;
    import cordic_pkg::*;

    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    cordic_rotator_if bus();

    cordic_rotator #(
        .ITER (18),
        .IW   (20),
        .ZW   (22)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clamp_round(input real v);
        real r;
        r = $floor(v + 0.5);
        if (r > 2047.0) return 2047;
        if (r < -2048.0) return -2048;
        return $rtoi(r);
    endfunction

    // Ideal result in output LSBs: magnitude (LSB 1/256) times cos/sin of the phase.
    function automatic void model(input int mag, input int phase, output int ex, output int ey);
        real ang;
        ang = 2.0 * PI * real'(phase) / 2097152.0;
        ex  = clamp_round(real'(mag) * $cos(ang));
        ey  = clamp_round(real'(mag) * $sin(ang));
    endfunction

    // Present one sample on the first idle negedge; the accept edge is the next posedge.
    task automatic send(input logic [11:0] mag, input logic [20:0] phase);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.in_mag   = mag;
        bus.in_phase = phase;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_mag   = 12'($urandom);
        bus.in_phase = 21'($urandom);
    endtask

    // Send one sample and return how many edges after accept out_valid appeared (-1 = never).
    task automatic run_txn(input logic [11:0] mag, input logic [20:0] phase,
                           output int lat, output int ox, output int oy, output logic rdy);
        send(mag, phase);
        lat = -1;
        ox  = 0;
        oy  = 0;
        rdy = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = k;
                ox  = int'(bus.out_x);
                oy  = int'(bus.out_y);
                rdy = bus.in_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_mag   = '0;
        bus.in_phase = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_x !== 12'h000 || bus.out_y !== 12'h000) begin
            errors++;
            $display("FAIL reset_out_xy: got %h/%h want 000/000", bus.out_x, bus.out_y);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_axes();
        logic [20:0] phs [6] = '{21'h000000, 21'h080000, 21'h100000,
                                 21'h180000, 21'h040000, 21'h1C0000};
        logic [11:0] mags [6] = '{12'h100, 12'h100, 12'h100, 12'h100, 12'h200, 12'h200};
        int   lat, ox, oy, ex, ey;
        logic rdy;
        for (int i = 0; i < 6; i++) begin
            run_txn(mags[i], phs[i], lat, ox, oy, rdy);
            model(int'(mags[i]), int'(phs[i]), ex, ey);
            checks++;
            if (lat != 19) begin
                errors++;
                $display("FAIL axes_latency[%0d]: got %0d cycles want 19", i, lat);
            end
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL axes_ready_with_valid[%0d]: got %b want 1", i, rdy);
            end
            checks++;
            if (iabs(ox - ex) > 2) begin
                errors++;
                $display("FAIL axes_x[%0d]: got %0d want %0d +/-2", i, ox, ex);
            end
            checks++;
            if (iabs(oy - ey) > 2) begin
                errors++;
                $display("FAIL axes_y[%0d]: got %0d want %0d +/-2", i, oy, ey);
            end
            // Strobe lasts one cycle; the outputs keep the result afterwards.
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL axes_pulse_width[%0d]: out_valid got %b want 0", i, bus.out_valid);
            end
            checks++;
            if (iabs(int'(bus.out_x) - ex) > 2 || iabs(int'(bus.out_y) - ey) > 2) begin
                errors++;
                $display("FAIL axes_hold[%0d]: got %0d/%0d want %0d/%0d +/-2",
                         i, int'(bus.out_x), int'(bus.out_y), ex, ey);
            end
        end
    endtask

    task automatic test_saturation();
        int   lat, ox, oy;
        logic rdy;
        run_txn(12'hF00, 21'h000000, lat, ox, oy, rdy);
        checks++;
        if (ox != 2047) begin
            errors++;
            $display("FAIL sat_pos_x: got %0d want 2047", ox);
        end
        checks++;
        if (iabs(oy) > 2) begin
            errors++;
            $display("FAIL sat_pos_y: got %0d want 0 +/-2", oy);
        end
        run_txn(12'hF00, 21'h100000, lat, ox, oy, rdy);
        checks++;
        if (ox != -2048) begin
            errors++;
            $display("FAIL sat_neg_x: got %0d want -2048", ox);
        end
        checks++;
        if (iabs(oy) > 2) begin
            errors++;
            $display("FAIL sat_neg_y: got %0d want 0 +/-2", oy);
        end
    endtask

    task automatic test_zero_mag();
        int          lat, ox, oy;
        logic        rdy;
        logic [20:0] ph;
        for (int i = 0; i < 4; i++) begin
            ph = 21'($urandom);
            run_txn(12'h000, ph, lat, ox, oy, rdy);
            checks++;
            if (ox != 0 || oy != 0) begin
                errors++;
                $display("FAIL zero_mag[%0d]: phase %h got %0d/%0d want 0/0", i, ph, ox, oy);
            end
        end
    endtask

    task automatic test_random();
        int          lat, ox, oy, ex, ey;
        logic        rdy;
        logic [11:0] mag;
        logic [20:0] ph;
        for (int i = 0; i < 16; i++) begin
            mag = 12'($urandom);
            ph  = 21'($urandom);
            run_txn(mag, ph, lat, ox, oy, rdy);
            model(int'(mag), int'(ph), ex, ey);
            checks++;
            if (lat != 19 || iabs(ox - ex) > 2 || iabs(oy - ey) > 2) begin
                errors++;
                $display("FAIL random[%0d]: mag %h phase %h got lat %0d x %0d y %0d want lat 19 x %0d y %0d +/-2",
                         i, mag, ph, lat, ox, oy, ex, ey);
            end
        end
    endtask

    // in_valid stays high; only the samples offered when the engine should be idle count.
    task automatic test_back_to_back();
        logic [11:0] mags [3];
        logic [20:0] phs [3];
        int          pulses, ex, ey, idx;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            mags[i] = 12'($urandom_range(16, 2047));
            phs[i]  = 21'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
        for (int n = 0; n <= 60; n++) begin
            checks++;
            if (bus.in_ready !== 1'((n % 20) == 0)) begin
                errors++;
                $display("FAIL b2b_in_ready[%0d]: got %b want %b", n, bus.in_ready, ((n % 20) == 0));
            end
            if (bus.out_valid === 1'b1) begin
                pulses++;
                checks++;
                if ((n % 20) != 0 || n == 0) begin
                    errors++;
                    $display("FAIL b2b_pulse_time: out_valid at cycle %0d want cycles 20/40/60", n);
                end else begin
                    idx = n / 20 - 1;
                    model(int'(mags[idx]), int'(phs[idx]), ex, ey);
                    if (iabs(int'(bus.out_x) - ex) > 2 || iabs(int'(bus.out_y) - ey) > 2) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got %0d/%0d want %0d/%0d +/-2",
                                 idx, int'(bus.out_x), int'(bus.out_y), ex, ey);
                    end
                end
            end
            if (n < 60) begin
                bus.in_valid = 1'b1;
                if ((n % 20) == 0) begin
                    bus.in_mag   = mags[n / 20];
                    bus.in_phase = phs[n / 20];
                end else begin
                    bus.in_mag   = 12'($urandom);
                    bus.in_phase = 21'($urandom);
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d want 3", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int   lat, ox, oy, ex, ey, pulses;
        logic rdy;
        pulses = 0;
        // Leave non-zero outputs behind so clearing them is observable.
        run_txn(12'h100, 21'h040000, lat, ox, oy, rdy);
        send(12'h300, 21'($urandom));
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_x !== 12'h000 || bus.out_y !== 12'h000) begin
            errors++;
            $display("FAIL midreset_clear: got valid %b x %h y %h want 0/000/000",
                     bus.out_valid, bus.out_x, bus.out_y);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b want 1", bus.in_ready);
        end
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_no_pulse: got %0d pulses want 0", pulses);
        end
        run_txn(12'h180, 21'h0A0000, lat, ox, oy, rdy);
        model(12'h180, 21'h0A0000, ex, ey);
        checks++;
        if (lat != 19 || iabs(ox - ex) > 2 || iabs(oy - ey) > 2) begin
            errors++;
            $display("FAIL midreset_recover: got lat %0d x %0d y %0d want lat 19 x %0d y %0d +/-2",
                     lat, ox, oy, ex, ey);
        end
    endtask

    initial begin
        test_reset();
        test_axes();
        test_saturation();
        test_zero_mag();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_rotator.md
Name: cordic_rotator

Overview:
- Rotation-mode CORDIC. Converts polar input (unsigned magnitude, unsigned 21-bit phase) to rectangular signed x/y.
- Inverse partner of the vectoring CORDIC, which turns x/y into magnitude/phase. Used for round-trip checks and for generating test vectors for that block.
- Single iterative engine, one sample in flight, valid/ready on the input side, one-cycle valid pulse on the output side.

Parameters:
- ITER, 18, number of micro-rotations; the atan table has 18 entries, so legal range is 12..18.
- IW, 20, internal signed x/y width (sign, 5 int, 14 frac).
- ZW, 22, internal signed residual-angle width (same LSB as phase).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input sample valid
- in_ready  output  1  engine idle; a sample is accepted when in_valid and in_ready are both high at a clk edge
- in_mag  input  12  unsigned, 4 int + 8 frac
- in_phase  input  21  unsigned; full scale 2^21 = 360 deg, 0x080000 = 90 deg, LSB = 360/2^21 deg
- out_valid  output  1  one-cycle result strobe
- out_x  output  12  signed, 1 sign + 3 int + 8 frac, saturated
- out_y  output  12  signed, same format as out_x

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE, out_valid=0, out_x=0, out_y=0, all internal registers 0. in_ready=1 once rst deasserts.
- FSM states: IDLE, ITER, POST.
  - IDLE: in_ready=1. On accept (edge E0), load registers and go to ITER.
  - ITER: counter i runs 0..ITER-1, one micro-rotation per edge. After i=ITER-1, go to POST.
  - POST: register outputs, pulse out_valid, return to IDLE.
- in_ready = (state==IDLE). in_valid outside IDLE is ignored; no data is captured.
- Latency with ITER=18:
  - Accept at edge E0, iterations at E1..E18, outputs registered at E19.
  - out_valid is high for exactly one cycle after E19. in_ready rises in that same cycle.
  - A new sample may be accepted on E20. Throughput is 1 sample per 20 cycles.
- Load at E0:
  - q = in_phase[20:19] (quadrant).
  - z = zero-extended in_phase[18:0], range 0 to <90 deg, within CORDIC convergence.
  - x = (in_mag * KINV) aligned to 14 frac bits. KINV = 0x26DD (1.14 format, 0.607239). Product is 27 bits with 22 frac bits; drop 8 LSBs by truncation.
  - y = 0.
- Iteration i (d = +1 if z>=0 else -1):
  - x <= x - d*(y>>>i)
  - y <= y + d*(x>>>i)
  - z <= z - d*ATAN[i]
  - Shifts are arithmetic. Wrap is impossible in IW=20.
- ATAN[i], phase LSBs: 40000, 25C81, 13F67, A222, 5162, 28BB, 145F, A30, 518, 28B, 146, A3, 51, 29, 14, A, 5, 3 (hex).
- POST quadrant map:
  - q=0: (x, y)
  - q=1: (-y, x)
  - q=2: (-x, -y)
  - q=3: (y, -x)
- POST scaling and saturation:
  - Round half-up: add 1<<5, then shift right 6, arithmetic.
  - Saturate to [-2048, 2047].
- out_x/out_y hold their value after out_valid drops, until the next POST.
- Accuracy: |error| <= 2 LSB per axis versus ideal mag*cos/sin for non-saturated results.
- Reset mid-operation: the state machine and outputs are cleared immediately. No out_valid for the aborted sample.
- in_mag=0 gives exactly 0/0 for any phase.

Decomposition:
- Shared package cordic_pkg holds:
  - ATAN table, KINV constant, ITER default.
  - Quadrant encoding.
  - Fixed-point format widths: 4.8 magnitude, 1.20 phase, s3.8 cartesian.
  - Also imported by the vectoring block.
- One sub-module, cordic_rot_post: quadrant map, rounding and saturation. Combinational, registered by the parent.

Test Plan:
- mag=0x100, phase=0x000000 -> out_x=0x100±2, out_y=0x000±2; out_valid exactly 19 cycles after the accept edge.
- mag=0x100, phase=0x080000 (90 deg) -> out_x=0±2, out_y=0x100±2; phase=0x100000 -> out_x=0xF00±2, out_y=0±2.
- mag=0x200, phase=0x040000 (45 deg) -> out_x=out_y=0x16A±2; phase=0x1C0000 (315 deg) -> out_x=0x16A, out_y=0xE96 (±2).
- mag=0xF00, phase=0 -> out_x=0x7FF (saturated), out_y=0; phase=0x100000 -> out_x=0x800.
- Back-to-back in_valid held high for 3 samples -> in_ready low during ITER/POST; samples accepted every 20 cycles; busy-time inputs ignored; 3 out_valid pulses.
- rst asserted at iteration 9 -> out_valid=0, out_x=out_y=0, in_ready=1 after release; next sample completes normally.
